ram_16k: RTL and testbench

- 16K-word x 16-bit random-access memory for the team's Hack-style computer (data memory tier above the 4K RAM).
- Synchronous write on rising clk when load is high.
- Asynchronous, combinational read of the addressed word.
- Built as four 4K banks selected by the top two address bits.

---
 rtl/ram_pkg.sv | 10 +
 rtl/ram_4k.sv | 32 +++
 rtl/ram_16k.sv | 46 ++++
 tb/tb_ram_16k.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the Hack-style RAM hierarchy.
// The 16K tier is four 4K banks selected by the upper address bits.
package ram_pkg;
  localparam int WORD_W        = 16;
  localparam int RAM16K_ADDR_W = 14;
  localparam int RAM4K_ADDR_W  = 12;
  localparam int NUM_BANKS     = 4;

  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/ram_4k.sv
// 4096 x 16 bank: synchronous write, combinational read.
// Asserting reset clears every word at once, without waiting for a clock edge.
module ram_4k
  import ram_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = RAM4K_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  output logic [WIDTH-1:0]  out
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Reset takes priority over load, so the array stays zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[address] <= in;
    end
  end

  assign out = mem[address];

endmodule

// File: rtl/ram_16k.sv
// 16K x 16 data memory built from four 4K banks.
// The top address bits route the write enable to one bank and pick that bank's read data.
module ram_16k
  import ram_pkg::*;
#(
  parameter int WIDTH       = WORD_W,
  parameter int ADDR_W      = RAM16K_ADDR_W,
  parameter int BANK_ADDR_W = RAM4K_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  output logic [WIDTH-1:0]  out
);

  localparam int SEL_W = ADDR_W - BANK_ADDR_W;

  logic [SEL_W-1:0]       bank_sel;
  logic [BANK_ADDR_W-1:0] bank_addr;
  logic [NUM_BANKS-1:0]   bank_load;
  logic [WIDTH-1:0]       bank_out [NUM_BANKS];

  assign bank_sel  = address[ADDR_W-1:BANK_ADDR_W];
  assign bank_addr = address[BANK_ADDR_W-1:0];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_load[b] = load && (bank_sel == SEL_W'(b));

    ram_4k #(
      .WIDTH  (WIDTH),
      .ADDR_W (BANK_ADDR_W)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .address (bank_addr),
      .load    (bank_load[b]),
      .out     (bank_out[b])
    );
  end

  assign out = bank_out[bank_sel];

endmodule

// File: tb/tb_ram_16k.sv
// Directed bench for ram_16k: expected words are queued when a read is set up
// and popped when the combinational output is sampled.
module tb_ram_16k;
  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        load    = 1'b0;
  logic [15:0] in      = '0;
  logic [13:0] address = '0;
  logic [15:0] out;

  int tests_run  = 0;
  int fail_count = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];

  ram_16k dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .address (address),
    .load    (load),
    .out     (out)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [13:0] a, input logic [15:0] d, input logic ld);
    address = a;
    in      = d;
    load    = ld;
  endtask

  task automatic pushExpect(input logic [15:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput();
    logic [15:0] e;
    string       t;
    tests_run++;
    if (exp_q.size() == 0) begin
      fail_count++;
      $error("[TB] FAIL scoreboard_empty: out=%h expected=<queued value>", out);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (out === e)
      else begin
        fail_count++;
        $error("[TB] FAIL %s: out=%h expected=%h", t, out, e);
      end
    end
  endtask

  task automatic writeWord(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    applyStimulus(a, d, 1'b1);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic expectRead(input logic [13:0] a, input logic [15:0] e, input string tag);
    address = a;
    pushExpect(e, tag);
    #1;
    checkOutput();
  endtask

  initial begin
    // Initial reset: contents start undefined, so out must be forced to zero.
    #1 reset = 1'b1;
    #1;
    pushExpect(16'h0000, "reset_hold");
    checkOutput();
    reset = 1'b0;

    // Asynchronous clear between clock edges.
    writeWord(14'd5, 16'hFFFF);
    expectRead(14'd5, 16'hFFFF, "pre_reset_5");
    @(negedge clk);
    #1 reset = 1'b1;
    expectRead(14'd5,     16'h0000, "reset_clr_5");
    expectRead(14'd0,     16'h0000, "reset_clr_0");
    expectRead(14'd4095,  16'h0000, "reset_clr_4095");
    expectRead(14'd4096,  16'h0000, "reset_clr_4096");
    expectRead(14'd16383, 16'h0000, "reset_clr_16383");
    reset = 1'b0;

    // Basic write/read.
    writeWord(14'd0, 16'h0000);
    writeWord(14'd1, 16'hFFFF);
    writeWord(14'd3, 16'hFF00);
    writeWord(14'd4, 16'h0F0F);
    writeWord(14'd7, 16'hCCCC);
    expectRead(14'd0, 16'h0000, "basic_0");
    expectRead(14'd1, 16'hFFFF, "basic_1");
    expectRead(14'd3, 16'hFF00, "basic_3");
    expectRead(14'd4, 16'h0F0F, "basic_4");
    expectRead(14'd7, 16'hCCCC, "basic_7");

    // Load gating, then read-during-write on the same address.
    @(negedge clk);
    applyStimulus(14'd2, 16'h00FF, 1'b0);
    #1;
    pushExpect(16'h0000, "gate_pre");
    checkOutput();
    @(posedge clk);
    #1;
    pushExpect(16'h0000, "gate_load0");
    checkOutput();
    @(negedge clk);
    load = 1'b1;
    #1;
    pushExpect(16'h0000, "rdw_old");
    checkOutput();
    @(posedge clk);
    #1;
    pushExpect(16'h00FF, "rdw_new");
    checkOutput();
    load = 1'b0;

    // Overwrite and isolation within bank 0.
    writeWord(14'd20, 16'h0000);
    writeWord(14'd28, 16'h0F09);
    writeWord(14'd32, 16'hF6F0);
    writeWord(14'd41, 16'h333B);
    writeWord(14'd56, 16'hCCCD);
    writeWord(14'd3,  16'hF900);
    expectRead(14'd3,  16'hF900, "ovw_3");
    expectRead(14'd28, 16'h0F09, "ovw_28");
    expectRead(14'd32, 16'hF6F0, "ovw_32");
    expectRead(14'd41, 16'h333B, "ovw_41");
    expectRead(14'd56, 16'hCCCD, "ovw_56");
    expectRead(14'd20, 16'h0000, "ovw_20");
    expectRead(14'd4,  16'h0F0F, "ovw_4_kept");

    // Bank boundaries.
    writeWord(14'd4095,  16'hA001);
    writeWord(14'd4096,  16'hA002);
    writeWord(14'd12287, 16'hA003);
    writeWord(14'd16383, 16'hA004);
    expectRead(14'd4095,  16'hA001, "bnd_4095");
    expectRead(14'd4096,  16'hA002, "bnd_4096");
    expectRead(14'd12287, 16'hA003, "bnd_12287");
    expectRead(14'd16383, 16'hA004, "bnd_16383");
    expectRead(14'd0,     16'h0000, "bnd_nb_0");
    expectRead(14'd1,     16'hFFFF, "bnd_nb_1");
    expectRead(14'd4094,  16'h0000, "bnd_nb_4094");
    expectRead(14'd8192,  16'h0000, "bnd_nb_8192");
    expectRead(14'd12288, 16'h0000, "bnd_nb_12288");
    expectRead(14'd16382, 16'h0000, "bnd_nb_16382");
    expectRead(14'd12,    16'h0000, "bnd_alias_12");

    // Reset priority over load, then normal write after release.
    @(negedge clk);
    applyStimulus(14'd100, 16'h1234, 1'b1);
    #1 reset = 1'b1;
    #1;
    pushExpect(16'h0000, "rstpri_async");
    checkOutput();
    @(posedge clk);
    #1;
    pushExpect(16'h0000, "rstpri_edge");
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    pushExpect(16'h1234, "rstpri_release");
    checkOutput();
    load = 1'b0;
    expectRead(14'd3,     16'h0000, "rstpri_clr_3");
    expectRead(14'd16383, 16'h0000, "rstpri_clr_16383");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
